// File: rtl/test_source_rand_delay.sv
// Val/rdy test source: messages loaded through a write port are issued in order,
// separated by LFSR-driven idle gaps, with replay, loop mode and a sent counter.
module test_source_rand_delay #(
  parameter int unsigned p_msg_nbits = 32,
  parameter int unsigned p_num_msgs  = 1024,
  parameter int unsigned p_max_delay = 0,
  parameter logic [15:0] p_seed      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_en,
  input  logic [p_msg_nbits-1:0] ld_msg,
  output logic                   ld_full,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   loop,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done,
  output logic [31:0]            num_sent
);

  localparam int unsigned AW = $clog2(p_num_msgs);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = (p_max_delay < 2) ? 1 : $clog2(p_max_delay + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SEND,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          count_q, count_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [31:0]            num_sent_q, num_sent_d;
  logic                   loop_q, loop_d;
  logic                   val_q, val_d;
  logic                   done_q, done_d;
  logic                   full_q, full_d;
  logic [p_msg_nbits-1:0] msg_q, msg_d;

  logic [p_msg_nbits-1:0] mem_q [p_num_msgs];

  logic [DW-1:0] dly_c;
  logic [PW-1:0] last_c;
  logic          full_c;
  logic          wr_en_c;

  // Galois LFSR x^16+x^14+x^13+x^11; free-running outside reset
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign dly_c  = DW'(32'(lfsr_q) % (p_max_delay + 1));
  assign last_c = count_q - PW'(1);
  assign full_c = (count_q == PW'(p_num_msgs));

  // Next-state and control
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    dcnt_d     = dcnt_q;
    num_sent_d = num_sent_q;
    loop_d     = loop_q;
    wr_en_c    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (clear) begin
          count_d = '0;
        end else if (start) begin
          loop_d     = loop;
          rd_ptr_d   = '0;
          num_sent_d = '0;
          if (count_q == '0) begin
            state_d = S_DONE;
          end else if (dly_c == '0) begin
            state_d = S_SEND;
          end else begin
            state_d = S_DELAY;
            dcnt_d  = dly_c;
          end
        end else if (ld_en && !full_c) begin
          wr_en_c = 1'b1;
          count_d = count_q + PW'(1);
        end
      end
      S_DELAY: begin
        dcnt_d = dcnt_q - DW'(1);
        if (dcnt_q == DW'(1)) state_d = S_SEND;
      end
      S_SEND: begin
        if (rdy) begin
          num_sent_d = num_sent_q + 32'd1;
          if ((rd_ptr_q == last_c) && !loop_q) begin
            state_d = S_DONE;
          end else begin
            rd_ptr_d = (rd_ptr_q == last_c) ? '0 : rd_ptr_q + PW'(1);
            if (dly_c != '0) begin
              state_d = S_DELAY;
              dcnt_d  = dly_c;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so done and val never overlap
  always_comb begin
    val_d  = (state_d == S_SEND);
    done_d = (state_d == S_DONE);
    full_d = (count_d == PW'(p_num_msgs));
    msg_d  = val_d ? mem_q[rd_ptr_d[AW-1:0]] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      lfsr_q     <= p_seed;
      dcnt_q     <= '0;
      num_sent_q <= '0;
      loop_q     <= 1'b0;
      val_q      <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      msg_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      lfsr_q     <= lfsr_d;
      dcnt_q     <= dcnt_d;
      num_sent_q <= num_sent_d;
      loop_q     <= loop_d;
      val_q      <= val_d;
      done_q     <= done_d;
      full_q     <= full_d;
      msg_q      <= msg_d;
    end
  end

  // Message storage; the write pointer always equals the loaded count
  always_ff @(posedge clk) begin
    if (wr_en_c && !reset) mem_q[count_q[AW-1:0]] <= ld_msg;
  end

  assign val      = val_q;
  assign done     = done_q;
  assign ld_full  = full_q;
  assign msg      = msg_q;
  assign num_sent = num_sent_q;

  a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({val_q, rdy, ld_en, start}));

endmodule

// File: tb/tb_test_source_rand_delay.sv
// Bench for test_source_rand_delay: vector table plus directed sequences on a
// zero-delay instance, and randomized traffic on a delayed instance vs a model.
module tb_test_source_rand_delay;

  localparam int unsigned MAXD1 = 3;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk;
  logic        reset;
  logic        ld_en   [2];
  logic [31:0] ld_msg  [2];
  logic        ld_full [2];
  logic        clear   [2];
  logic        start   [2];
  logic        loop    [2];
  logic        val     [2];
  logic        rdy     [2];
  logic [31:0] msg     [2];
  logic        done    [2];
  logic [31:0] num_sent[2];

  int checks   = 0;
  int failures = 0;
  logic [15:0] m_lfsr;

  test_source_rand_delay #(.p_msg_nbits(32), .p_num_msgs(4), .p_max_delay(0), .p_seed(SEED)) u_d0 (
    .clk(clk), .reset(reset), .ld_en(ld_en[0]), .ld_msg(ld_msg[0]), .ld_full(ld_full[0]),
    .clear(clear[0]), .start(start[0]), .loop(loop[0]), .val(val[0]), .rdy(rdy[0]),
    .msg(msg[0]), .done(done[0]), .num_sent(num_sent[0]));

  test_source_rand_delay #(.p_msg_nbits(32), .p_num_msgs(16), .p_max_delay(MAXD1), .p_seed(SEED)) u_d1 (
    .clk(clk), .reset(reset), .ld_en(ld_en[1]), .ld_msg(ld_msg[1]), .ld_full(ld_full[1]),
    .clear(clear[1]), .start(start[1]), .loop(loop[1]), .val(val[1]), .rdy(rdy[1]),
    .msg(msg[1]), .done(done[1]), .num_sent(num_sent[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Golden LFSR: holds the value the DUT will use at the coming edge
  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= lfsr_next(m_lfsr);

  typedef struct {
    logic        ld_en;
    logic [31:0] ld_msg;
    logic        clear;
    logic        start;
    logic        rdy;
    logic        exp_val;
    logic [31:0] exp_msg;
    logic        exp_done;
    logic        exp_full;
    logic [31:0] exp_sent;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mkv(input int le, input int lm, input int cl, input int st, input int r,
                               input int ev, input int em, input int ed, input int ef, input int es);
    vec_t v;
    v.ld_en = 1'(le); v.ld_msg = 32'(lm); v.clear = 1'(cl); v.start = 1'(st); v.rdy = 1'(r);
    v.exp_val = 1'(ev); v.exp_msg = 32'(em); v.exp_done = 1'(ed); v.exp_full = 1'(ef);
    v.exp_sent = 32'(es);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int k, input logic ev, input logic [31:0] em,
                         input logic ed, input logic [31:0] es);
    chk({nm, "_val"}, 32'(val[k]), 32'(ev));
    chk({nm, "_msg"}, msg[k], em);
    chk({nm, "_done"}, 32'(done[k]), 32'(ed));
    chk({nm, "_sent"}, num_sent[k], es);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      ld_en[k] = 0; ld_msg[k] = '0; clear[k] = 0; start[k] = 0; loop[k] = 0; rdy[k] = 0;
    end
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic load(input int k, input logic [31:0] v);
    ld_en[k] = 1'b1; ld_msg[k] = v;
    step();
    ld_en[k] = 1'b0;
  endtask

  task automatic rand_round(input int n);
    logic [31:0] q[$];
    int gap, idx, cyc;
    logic r;
    clear[1] = 1'b1;
    step();
    clear[1] = 1'b0;
    q = {};
    for (int i = 0; i < n; i++) begin
      q.push_back($urandom);
      load(1, q[i]);
    end
    chk("rnd_full", 32'(ld_full[1]), 32'(n == 16));
    rdy[1] = 1'b0;
    start[1] = 1'b1;
    gap = int'(m_lfsr % 16'(MAXD1 + 1));
    step();
    start[1] = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 400) begin
      cyc++;
      if (gap > 0) begin
        chk("rnd_gap_val", 32'(val[1]), 32'd0);
        chk("rnd_gap_msg", msg[1], 32'd0);
        gap--;
        rdy[1] = 1'($urandom_range(0, 1));
      end else begin
        chk("rnd_val", 32'(val[1]), 32'd1);
        chk("rnd_msg", msg[1], q[idx]);
        r = ($urandom_range(0, 3) != 0);
        rdy[1] = r;
        if (r) begin
          gap = int'(m_lfsr % 16'(MAXD1 + 1));
          idx++;
        end
      end
      step();
    end
    rdy[1] = 1'b0;
    if (idx < n) begin
      checks++;
      failures++;
      $display("FAIL rnd_timeout: got %0d transfers expected %0d", idx, n);
    end
    chk_out("rnd_end", 1, 1'b0, 32'd0, 1'b1, 32'(n));
  endtask

  initial begin
    reset = 1'b1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk_out($sformatf("rst%0d", k), k, 1'b0, 32'd0, 1'b0, 32'd0);
      chk($sformatf("rst%0d_full", k), 32'(ld_full[k]), 32'd0);
    end

    // ld, msg, clr, st, rdy -> val, msg, done, full, sent
    vt[0]  = mkv(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    vt[1]  = mkv(1, 2, 0, 0, 0,  0, 0, 0, 0, 0);
    vt[2]  = mkv(1, 3, 0, 0, 0,  0, 0, 0, 0, 0);
    vt[3]  = mkv(1, 4, 0, 0, 0,  0, 0, 0, 1, 0);
    vt[4]  = mkv(1, 5, 0, 0, 0,  0, 0, 0, 1, 0);
    vt[5]  = mkv(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    vt[6]  = mkv(0, 0, 0, 1, 0,  1, 1, 0, 1, 0);
    vt[7]  = mkv(0, 0, 0, 0, 1,  1, 2, 0, 1, 1);
    vt[8]  = mkv(0, 0, 0, 0, 1,  1, 3, 0, 1, 2);
    vt[9]  = mkv(0, 0, 0, 0, 1,  1, 4, 0, 1, 3);
    vt[10] = mkv(0, 0, 0, 0, 1,  0, 0, 1, 1, 4);
    vt[11] = mkv(0, 0, 1, 0, 0,  0, 0, 1, 0, 4);
    vt[12] = mkv(1, 9, 1, 1, 0,  0, 0, 1, 0, 4);
    vt[13] = mkv(1, 8, 0, 1, 0,  0, 0, 1, 0, 0);
    vt[14] = mkv(1, 7, 0, 0, 0,  0, 0, 1, 0, 0);
    vt[15] = mkv(0, 0, 0, 1, 0,  1, 7, 0, 0, 0);
    vt[16] = mkv(0, 0, 0, 0, 1,  0, 0, 1, 0, 1);
    for (int i = 0; i < 17; i++) begin
      ld_en[0] = vt[i].ld_en; ld_msg[0] = vt[i].ld_msg; clear[0] = vt[i].clear;
      start[0] = vt[i].start; rdy[0] = vt[i].rdy;
      step();
      chk_out($sformatf("vec%0d", i), 0, vt[i].exp_val, vt[i].exp_msg, vt[i].exp_done, vt[i].exp_sent);
      chk($sformatf("vec%0d_full", i), 32'(ld_full[0]), 32'(vt[i].exp_full));
    end

    // Back-to-back, then replay under backpressure
    do_reset();
    load(0, 32'h11); load(0, 32'h22); load(0, 32'h33);
    rdy[0] = 1'b1; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk_out("b2b0", 0, 1'b1, 32'h11, 1'b0, 32'd0);
    step(); chk_out("b2b1", 0, 1'b1, 32'h22, 1'b0, 32'd1);
    step(); chk_out("b2b2", 0, 1'b1, 32'h33, 1'b0, 32'd2);
    step(); chk_out("b2b_done", 0, 1'b0, 32'd0, 1'b1, 32'd3);
    rdy[0] = 1'b0; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_out($sformatf("bp_hold%0d", c), 0, 1'b1, 32'h11, 1'b0, 32'd0);
      if (c < 4) step();
    end
    rdy[0] = 1'b1;
    step(); chk_out("bp1", 0, 1'b1, 32'h22, 1'b0, 32'd1);
    step(); chk_out("bp2", 0, 1'b1, 32'h33, 1'b0, 32'd2);
    step(); chk_out("bp_done", 0, 1'b0, 32'd0, 1'b1, 32'd3);

    // Loop mode, then async reset between edges
    do_reset();
    load(0, 32'hA); load(0, 32'hB);
    rdy[0] = 1'b1; loop[0] = 1'b1; start[0] = 1'b1;
    step();
    start[0] = 1'b0; loop[0] = 1'b0;
    chk_out("loop0", 0, 1'b1, 32'hA, 1'b0, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk_out($sformatf("loop%0d", i), 0, 1'b1, (i % 2 == 0) ? 32'hA : 32'hB, 1'b0, 32'(i));
    end
    #3;
    reset = 1'b1;
    #1;
    chk_out("areset", 0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("areset_full", 32'(ld_full[0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; rdy[0] = 1'b0; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk_out("empty_start", 0, 1'b0, 32'd0, 1'b1, 32'd0);
    step();
    chk_out("empty_hold", 0, 1'b0, 32'd0, 1'b1, 32'd0);

    // Randomized traffic with LFSR gaps on the delayed instance
    do_reset();
    rand_round(8);
    rand_round(16);
    rand_round(int'($urandom_range(1, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/test_source_rand_delay.md
Name: test_source_rand_delay

Overview:
Next-generation test source for latency-insensitive val/rdy benches. Messages are written through a load port instead of a behavioural file task, then issued on a val/rdy source interface. Successive messages are separated by an LFSR-driven pseudo-random idle gap. The block adds replay and loop modes and a sent-message counter. It sits in testbenches in front of the DUT input, paired with a test sink.

Parameters:
p_msg_nbits  32  message width in bits
p_num_msgs  1024  message memory depth (>=2)
p_max_delay  0  maximum idle cycles inserted before each message; 0 disables delay
p_seed  16'hACE1  LFSR reset value; must be nonzero

Ports:
clk  input  1  clock
reset  input  1  reset: asynchronous, active-high; clears all state
ld_en  input  1  write ld_msg into memory at the write pointer
ld_msg  input  p_msg_nbits  message to load
ld_full  output  1  high when the loaded count equals p_num_msgs
clear  input  1  discard loaded messages (IDLE/DONE only)
start  input  1  begin issuing from index 0 (IDLE/DONE only)
loop  input  1  sampled at start; 1 means wrap to index 0 forever
val  output  1  source valid
rdy  input  1  sink ready
msg  output  p_msg_nbits  source message
done  output  1  high once all messages are sent (non-loop)
num_sent  output  32  count of completed transfers since start, wrapping

Behaviour:
- Reset (async assert):
  - State=IDLE; wr_ptr=0; count=0; rd_ptr=0; lfsr=p_seed; num_sent=0; loop_r=0.
  - val=0, done=0, ld_full=0, msg=0.
  - Asserting reset mid-transfer drops val in the same cycle, without waiting for a clock edge.
- msg=m[rd_ptr] while val=1, else 0.
- LFSR: 16-bit Galois, taps 16,14,13,11. It advances every clock edge outside reset.
- Delay load value: d = lfsr mod (p_max_delay+1), computed each time a delay is entered.
- State IDLE:
  - ld_en && !ld_full: m[wr_ptr]<=ld_msg; wr_ptr++; count++. ld_en while ld_full is ignored; no wrap.
  - clear: wr_ptr=0, count=0.
  - start: loop_r<=loop; rd_ptr=0; num_sent=0.
    - count==0 → DONE.
    - p_max_delay==0 or d==0 → SEND.
    - Otherwise → DELAY with dcnt=d.
  - Priority within one cycle: clear > start > ld_en. A lower-priority request in the same cycle is dropped.
- State DELAY: val=0; dcnt--. dcnt==1 → SEND, so exactly d idle cycles are inserted.
- State SEND: val=1 and msg held stable until rdy. On val&&rdy, num_sent++, then:
  - rd_ptr==count-1, loop_r=0 → DONE.
  - rd_ptr==count-1, loop_r=1 → rd_ptr=0; next-delay rule applies.
  - Otherwise rd_ptr++; next-delay rule applies.
  - Next-delay rule: d==0 → stay in SEND (back-to-back, full throughput); else → DELAY.
- State DONE:
  - done=1, val=0.
  - ld_en appends messages (allowed while count<p_num_msgs).
  - clear and start behave as in IDLE. start replays from index 0 and deasserts done on the next cycle.
- ld_en, clear and start are ignored in DELAY and SEND.
- done is registered. It rises on the edge that completes the final transfer, so val and done are never high together.
- Loop mode never reaches DONE. Exit it by reset only.
- The rdy input has no effect outside SEND.
- Widths:
  - Pointers and count use $clog2(p_num_msgs)+1 bits, so count can reach p_num_msgs.
  - num_sent wraps 2^32-1 → 0.
- Assertions, active when not in reset: val, rdy, ld_en and start are not X.

Test Plan:
- Basic back-to-back: p_max_delay=0; load 0x11,0x22,0x33; start; rdy=1 → msg 0x11,0x22,0x33 on three consecutive cycles; done=1 on the next cycle; num_sent=3.
- Backpressure: same load; rdy low for cycles 0-4 after start → msg holds 0x11 with val=1 for five cycles; order is preserved; done after the third transfer.
- Random delay: p_max_delay=3; load 8 messages; rdy=1 → gaps between transfers lie in 0..3 and match a golden LFSR model seeded 16'hACE1; all 8 messages are delivered in order.
- Full/boundary: p_num_msgs=4; ld_en five times (values 1..5) → ld_full=1 after the fourth write; value 5 is dropped; sequence 1,2,3,4 is sent. A start with count=0 → done=1 on the next cycle with val never high.
- Loop and replay:
  - loop=1 with messages 0xA,0xB → A,B,A,B… continue; num_sent=6 after six transfers; done stays 0.
  - Separately, start in DONE → A,B replays; num_sent restarts at 0.
- Async reset mid-send: assert reset between clock edges while val=1 → val, done and msg go to 0 immediately; count=0. After reset, a start with nothing loaded → DONE.
